// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven bus master that turns host byte frames into single-word bus reads/writes
// Ports: clk/reset (async, active-high); rx_data/rx_empty/rd_uart pop the rx FIFO;
// tx_data/tx_full/wr_uart push the tx FIFO; addr/wdata/rdata/re/we form the word bus;
// cpu_hold keeps the CPU in reset and this block owning the bus while high.
module uart_bus_master #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [29:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        re,
  output logic [3:0]  we,
  output logic        cpu_hold
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] BUS_WR   = 3'd3;
  localparam logic [2:0] BUS_RD   = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] SEND     = 3'd6;

  logic [2:0]  state_q, state_d;
  logic        wr_cmd_q, wr_cmd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] txq_q, txq_d;
  logic [2:0]  txn_q, txn_d;
  logic [31:0] tmo_q, tmo_d;
  logic        hold_q, hold_d;

  // Pops only in byte-collecting states; gated by reset so nothing is consumed while held.
  assign rd_uart  = !reset && !rx_empty && (state_q == IDLE || state_q == GET_ADDR || state_q == GET_DATA);
  assign wr_uart  = state_q == SEND && !tx_full;
  assign tx_data  = state_q == SEND ? txq_q[7:0] : 8'h00;
  assign re       = state_q == BUS_RD;
  assign we       = {4{state_q == BUS_WR}};
  assign addr     = adr_q[31:2];
  assign wdata    = dat_q;
  assign cpu_hold = hold_q;

  always_comb begin
    state_d  = state_q;
    wr_cmd_d = wr_cmd_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    txq_d    = txq_q;
    txn_d    = txn_q;
    hold_d   = hold_q;
    tmo_d    = '0;
    case (state_q)
      IDLE: if (rd_uart) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          state_d  = GET_ADDR;
          wr_cmd_d = rx_data == 8'h57;
          cnt_d    = 2'd0;
        end else begin
          state_d = SEND;
          txn_d   = 3'd1;
          txq_d   = {24'h0, (rx_data == 8'h47 || rx_data == 8'h48) ? 8'h06 : 8'h15};
          hold_d  = rx_data == 8'h47 ? 1'b0 : rx_data == 8'h48 ? 1'b1 : hold_q;
        end
      end
      GET_ADDR: if (rd_uart) begin
        // Little-endian: each byte enters at the top and shifts down.
        adr_d = {rx_data, adr_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = wr_cmd_q ? GET_DATA : BUS_RD;
      end else if (tmo_q == 32'(TIMEOUT - 1)) state_d = IDLE;
      else tmo_d = tmo_q + 32'd1;
      GET_DATA: if (rd_uart) begin
        dat_d = {rx_data, dat_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = BUS_WR;
      end else if (tmo_q == 32'(TIMEOUT - 1)) state_d = IDLE;
      else tmo_d = tmo_q + 32'd1;
      BUS_WR: begin
        state_d = SEND;
        txq_d   = 32'h06;
        txn_d   = 3'd1;
      end
      BUS_RD: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = SEND;
        txq_d   = rdata;
        txn_d   = 3'd4;
      end
      SEND: if (!tx_full) begin
        txq_d = {8'h00, txq_q[31:8]};
        txn_d = txn_q - 3'd1;
        if (txn_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_cmd_q <= 1'b0;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      txq_q    <= '0;
      txn_q    <= '0;
      tmo_q    <= '0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_cmd_q <= wr_cmd_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      txq_q    <= txq_d;
      txn_q    <= txn_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
    end
  end
endmodule
